// File: rtl/irq_controller.sv
// Central interrupt controller.
// Peripheral interrupt pulses are latched into software-visible active flags.
// Each flag is qualified by a per-source enable and a per-group priority.
// One registered request, vector and priority level is presented to the CPU.
// The register window is 0x2020-0x202A on the 24-bit peripheral bus.

// Per-source cell: rising-edge detect on the line, then the active flag.
module irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_grp_on,
  output logic o_active,
  output logic o_pend
);
  logic r_irq_d;
  logic r_active;
  logic w_set;

  assign w_set = i_irq & ~r_irq_d;

  // Line history keeps sampling through reset, so a line that is already
  // high when reset deasserts does not produce a spurious edge.
  always_ff @(posedge clk) begin
    r_irq_d <= i_irq;
  end

  // Flag update: a new edge wins over a software clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) r_active <= 1'b0;
    else       r_active <= (r_active & ~i_clr) | w_set;
  end

  assign o_active = r_active;
  assign o_pend   = r_active & i_en & i_grp_on;
endmodule

module irq_controller #(
  parameter int          NUM_SRC     = 32,
  parameter logic [4:0]  BASE_VECTOR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic [31:0] irq_in,
  input  logic [1:0]  cpu_ilevel,
  output logic        irq_req,
  output logic [4:0]  irq_vector,
  output logic [1:0]  irq_priority
);
  localparam logic [23:0] A_PRIO_LO = 24'h002020;
  localparam logic [23:0] A_PRIO_HI = 24'h002021;
  localparam logic [23:0] A_EN0     = 24'h002023;
  localparam logic [23:0] A_EN1     = 24'h002024;
  localparam logic [23:0] A_EN2     = 24'h002025;
  localparam logic [23:0] A_EN3     = 24'h002026;
  localparam logic [23:0] A_ACT0    = 24'h002027;
  localparam logic [23:0] A_ACT1    = 24'h002028;
  localparam logic [23:0] A_ACT2    = 24'h002029;
  localparam logic [23:0] A_ACT3    = 24'h00202A;

  logic [7:0]                 r_prio_lo;
  logic [7:0]                 r_prio_hi;
  logic [NUM_SRC-1:0]         r_enable;
  logic                       r_irq_req;
  logic [4:0]                 r_irq_vector;
  logic [1:0]                 r_irq_priority;

  logic [15:0]                w_prio;
  logic [NUM_SRC-1:0][1:0]    w_src_pri;
  logic [NUM_SRC-1:0]         w_clr;
  logic [NUM_SRC-1:0]         w_active;
  logic [NUM_SRC-1:0]         w_pend;
  logic                       w_any;
  logic [4:0]                 w_win_idx;
  logic [1:0]                 w_win_pri;
  logic                       w_unused_rd;

  // Reads have no side effects, so the read strobe is not needed.
  assign w_unused_rd = bus_read;

  assign w_prio = {r_prio_hi, r_prio_lo};

  // W1C decode: each active byte clears only the bits written as 1.
  always_comb begin
    w_clr = '0;
    if (bus_write) begin
      case (bus_address_in)
        A_ACT0:  w_clr[7:0]   = bus_data_in;
        A_ACT1:  w_clr[15:8]  = bus_data_in;
        A_ACT2:  w_clr[23:16] = bus_data_in;
        A_ACT3:  w_clr[31:24] = bus_data_in;
        default: w_clr = '0;
      endcase
    end
  end

  genvar s;
  generate
    for (s = 0; s < NUM_SRC; s++) begin : g_src
      // Sources share their group's 2-bit priority; group = s>>2.
      assign w_src_pri[s] = w_prio[2*(s/4) +: 2];

      irq_src_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .i_irq    (irq_in[s]),
        .i_clr    (w_clr[s]),
        .i_en     (r_enable[s]),
        .i_grp_on (w_src_pri[s] != 2'd0),
        .o_active (w_active[s]),
        .o_pend   (w_pend[s])
      );
    end
  endgenerate

  // Priority and enable register writes; unmapped addresses are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio_lo <= 8'h00;
      r_prio_hi <= 8'h00;
      r_enable  <= '0;
    end else if (bus_write) begin
      case (bus_address_in)
        A_PRIO_LO: r_prio_lo       <= bus_data_in;
        A_PRIO_HI: r_prio_hi       <= bus_data_in;
        A_EN0:     r_enable[7:0]   <= bus_data_in;
        A_EN1:     r_enable[15:8]  <= bus_data_in;
        A_EN2:     r_enable[23:16] <= bus_data_in;
        A_EN3:     r_enable[31:24] <= bus_data_in;
        default:   ;
      endcase
    end
  end

  // Arbitration: ascending scan with a strict compare, so the lowest index
  // keeps the win among sources of equal group priority.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = 5'd0;
    w_win_pri = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_pend[i] && (!w_any || (w_src_pri[i] > w_win_pri))) begin
        w_any     = 1'b1;
        w_win_idx = 5'(i);
        w_win_pri = w_src_pri[i];
      end
    end
  end

  // CPU-facing outputs; vector and level hold when nothing is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_req      <= 1'b0;
      r_irq_vector   <= 5'd0;
      r_irq_priority <= 2'd0;
    end else begin
      r_irq_req <= w_any && (w_win_pri > cpu_ilevel);
      if (w_any) begin
        r_irq_vector   <= BASE_VECTOR + w_win_idx;
        r_irq_priority <= w_win_pri;
      end
    end
  end

  assign irq_req      = r_irq_req;
  assign irq_vector   = r_irq_vector;
  assign irq_priority = r_irq_priority;

  // Combinational read mux over the full 24-bit address.
  always_comb begin
    case (bus_address_in)
      A_PRIO_LO: bus_data_out = r_prio_lo;
      A_PRIO_HI: bus_data_out = r_prio_hi;
      A_EN0:     bus_data_out = r_enable[7:0];
      A_EN1:     bus_data_out = r_enable[15:8];
      A_EN2:     bus_data_out = r_enable[23:16];
      A_EN3:     bus_data_out = r_enable[31:24];
      A_ACT0:    bus_data_out = w_active[7:0];
      A_ACT1:    bus_data_out = w_active[15:8];
      A_ACT2:    bus_data_out = w_active[23:16];
      A_ACT3:    bus_data_out = w_active[31:24];
      default:   bus_data_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register vector table, then hand sequences whose
// CPU-side expectations go through a cycle-stamped scoreboard queue.
module tb_irq_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic [31:0] irq_in;
  logic [1:0]  cpu_ilevel;
  logic        irq_req;
  logic [4:0]  irq_vector;
  logic [1:0]  irq_priority;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  irq_controller dut (
    .clk            (clk),
    .reset          (reset),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .irq_in         (irq_in),
    .cpu_ilevel     (cpu_ilevel),
    .irq_req        (irq_req),
    .irq_vector     (irq_vector),
    .irq_priority   (irq_priority)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      name;
    logic       req;
    logic [4:0] vec;
    logic [1:0] pri;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Expected CPU outputs 'dly' posedges from now.
  task automatic exp_at(input int dly, input string nm, input logic r,
                        input logic [4:0] v, input logic [1:0] p);
    exp_t x;
    x.due = cyc + dly; x.name = nm; x.req = r; x.vec = v; x.pri = p;
    sbq.push_back(x);
  endtask

  // Scoreboard monitor: compares just after each negedge.
  always @(negedge clk) begin
    #2;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk({e.name, "_req"}, 32'(irq_req), 32'(e.req));
      chk({e.name, "_vec"}, 32'(irq_vector), 32'(e.vec));
      chk({e.name, "_pri"}, 32'(irq_priority), 32'(e.pri));
    end
  end

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    bus_write = 1'b1; bus_address_in = a; bus_data_in = d;
    @(negedge clk);
    bus_write = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a, input logic [7:0] want, input string nm);
    bus_address_in = a; bus_read = 1'b1;
    #1;
    chk(nm, 32'(bus_data_out), 32'(want));
    bus_read = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] m);
    irq_in = m;
    @(negedge clk);
    irq_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus_write = 1'b0; bus_read = 1'b0; bus_address_in = '0;
    bus_data_in = '0; irq_in = '0; cpu_ilevel = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    for (int a = 'h2020; a <= 'h202A; a++) rd(24'(a), 8'h00, "rst_reg");
    chk("rst_req", 32'(irq_req), 0);
    chk("rst_vec", 32'(irq_vector), 0);
    chk("rst_pri", 32'(irq_priority), 0);

    // Register write/readback table.
    tbl.push_back('{1'b1, 24'h002020, 8'hA5, 8'hA5});
    tbl.push_back('{1'b1, 24'h002021, 8'h3C, 8'h3C});
    tbl.push_back('{1'b1, 24'h002022, 8'hFF, 8'h00});
    tbl.push_back('{1'b1, 24'h002023, 8'h81, 8'h81});
    tbl.push_back('{1'b1, 24'h002024, 8'h42, 8'h42});
    tbl.push_back('{1'b1, 24'h002025, 8'h18, 8'h18});
    tbl.push_back('{1'b1, 24'h002026, 8'hF0, 8'hF0});
    tbl.push_back('{1'b1, 24'h002027, 8'hFF, 8'h00});
    tbl.push_back('{1'b1, 24'h002030, 8'h55, 8'h00});
    tbl.push_back('{1'b1, 24'h00201F, 8'h77, 8'h00});
    tbl.push_back('{1'b1, 24'h012020, 8'h11, 8'h00});
    tbl.push_back('{1'b0, 24'h002020, 8'h00, 8'hA5});
    tbl.push_back('{1'b0, 24'h002024, 8'h00, 8'h42});
    tbl.push_back('{1'b1, 24'h002020, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 24'h002021, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 24'h002023, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 24'h002024, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 24'h002025, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 24'h002026, 8'h00, 8'h00});
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wd);
      rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Single source: latency, W1C, held line sets once.
    wr(24'h002020, 8'h02);
    wr(24'h002023, 8'h01);
    exp_at(1, "A_pre", 1'b0, 5'd0, 2'd0);
    exp_at(2, "A_req", 1'b1, 5'd0, 2'd2);
    pulse(32'h1);
    rd(24'h002027, 8'h01, "A_act");
    @(negedge clk);
    exp_at(1, "A_hold", 1'b1, 5'd0, 2'd2);
    exp_at(2, "A_clr", 1'b0, 5'd0, 2'd2);
    wr(24'h002027, 8'h01);
    @(negedge clk);
    irq_in = 32'h1;
    exp_at(2, "H_req", 1'b1, 5'd0, 2'd2);
    exp_at(3, "H_clr", 1'b0, 5'd0, 2'd2);
    @(negedge clk);
    wr(24'h002027, 8'h01);
    repeat (3) @(negedge clk);
    rd(24'h002027, 8'h00, "H_once");
    irq_in = '0;
    @(negedge clk);

    // Higher group priority wins; clearing it exposes the lower one.
    wr(24'h002020, 8'h0D);
    wr(24'h002023, 8'h22);
    exp_at(2, "B_hi", 1'b1, 5'd5, 2'd3);
    pulse(32'h22);
    @(negedge clk);
    rd(24'h002027, 8'h22, "B_act");
    exp_at(2, "B_lo", 1'b1, 5'd1, 2'd1);
    wr(24'h002027, 8'h20);
    @(negedge clk);
    exp_at(2, "B_none", 1'b0, 5'd1, 2'd1);
    wr(24'h002027, 8'h02);
    @(negedge clk);

    // Equal priority in one group: lowest index.
    wr(24'h002020, 8'h2D);
    wr(24'h002024, 8'h06);
    exp_at(2, "C_tie", 1'b1, 5'd9, 2'd2);
    pulse(32'h600);
    @(negedge clk);
    exp_at(2, "C_clr", 1'b0, 5'd9, 2'd2);
    wr(24'h002028, 8'h06);
    @(negedge clk);

    // CPU level masking.
    wr(24'h002020, 8'h2E);
    wr(24'h002023, 8'h23);
    cpu_ilevel = 2'd2;
    exp_at(2, "D_mask", 1'b0, 5'd0, 2'd2);
    pulse(32'h1);
    repeat (2) @(negedge clk);
    exp_at(1, "D_unmask", 1'b1, 5'd0, 2'd2);
    cpu_ilevel = 2'd1;
    @(negedge clk);
    exp_at(2, "D_clr", 1'b0, 5'd0, 2'd2);
    wr(24'h002027, 8'h01);
    cpu_ilevel = 2'd0;
    @(negedge clk);

    // Disabled source latches; set beats same-cycle clear; late enable.
    exp_at(2, "F_off", 1'b0, 5'd0, 2'd2);
    pulse(32'h8);
    @(negedge clk);
    rd(24'h002027, 8'h08, "F_act");
    bus_write = 1'b1; bus_address_in = 24'h002027; bus_data_in = 8'h08;
    irq_in = 32'h8;
    @(negedge clk);
    bus_write = 1'b0; irq_in = '0;
    rd(24'h002027, 8'h08, "E_setwins");
    exp_at(2, "F_on", 1'b1, 5'd3, 2'd2);
    wr(24'h002023, 8'h2B);
    @(negedge clk);
    exp_at(2, "F_clr", 1'b0, 5'd3, 2'd2);
    wr(24'h002027, 8'h08);
    @(negedge clk);
    rd(24'h002027, 8'h00, "F_gone");

    // Priority 0 disables the whole group.
    wr(24'h002024, 8'h10);
    exp_at(2, "G_prio0", 1'b0, 5'd3, 2'd2);
    pulse(32'h1000);
    @(negedge clk);
    rd(24'h002028, 8'h10, "G_act");
    wr(24'h002028, 8'h10);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    #3;
    chk("sb_drain", 32'(sbq.size()), 0);

    // Line high across reset must not set a flag.
    irq_in = 32'h1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int a = 'h2020; a <= 'h202A; a++) rd(24'(a), 8'h00, "rst2_reg");
    chk("rst2_req", 32'(irq_req), 0);
    chk("rst2_vec", 32'(irq_vector), 0);
    chk("rst2_pri", 32'(irq_priority), 0);
    irq_in = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
